iter_div_unit: RTL and testbench

Parametrised iterative integer divider for the execution stage. It implements RISC-V M-extension DIV/DIVU/REM/REMU and their 32-bit W variants, and is the next generation of the single-mode radix-2 divider. Over its predecessor it adds:
- configurable width and bits-per-cycle;
- valid/ready handshakes with response backpressure;
- transaction tags;
- single-cycle early-out for divide-by-zero and signed overflow.

It sits beside the multiplier on the integer issue port; its response feeds the writeback arbiter.

---
 rtl/drac_pkg.sv | 26 ++
 rtl/iter_div_unit_if.sv | 34 +++
 rtl/div_step.sv | 23 ++
 rtl/iter_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_iter_div_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drac_pkg.sv
// Shared types for the iterative integer divider.
// Exports: div_op_t, div_state_t, op_signed(), op_rem().
package drac_pkg;

    typedef enum logic [1:0] {
        DIV,
        DIVU,
        REM,
        REMU
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } div_state_t;

    function automatic logic op_signed(div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_rem(div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// Request/response handshake bundle for iter_div_unit.
// master: issue side (drives req_*, resp_ready_i); slave: the divider.
interface iter_div_unit_if
    import drac_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
) ();

    logic             req_valid_i;
    logic             req_ready_o;
    div_op_t          req_op_i;
    logic             req_w_i;
    logic [TAG_W-1:0] req_tag_i;
    logic [XLEN-1:0]  req_dvnd_i;
    logic [XLEN-1:0]  req_dvsr_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_result_o;
    logic [TAG_W-1:0] resp_tag_o;

    modport master (
        output req_valid_i, req_op_i, req_w_i, req_tag_i,
        output req_dvnd_i, req_dvsr_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_tag_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_w_i, req_tag_i,
        input  req_dvnd_i, req_dvsr_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_tag_o
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step (combinational).
// Ports: rem/dvnd_bit/dvsr in; rem_next, q_bit out.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dvnd_bit,
    input  logic [XLEN-1:0] dvsr,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // rem < dvsr on entry, so the trial value needs one extra bit
    // and the restored remainder always fits back into XLEN bits.
    assign trial    = {rem, dvnd_bit};
    assign diff     = trial - {1'b0, dvsr};
    assign q_bit    = (trial >= {1'b0, dvsr});
    assign rem_next = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/iter_div_unit.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU and W forms).
// Ports: clk_i, rst_i (sync high), kill_i, bus (slave), busy_o.
module iter_div_unit
    import drac_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           kill_i,
    iter_div_unit_if.slave bus,
    output logic           busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam int HALF  = XLEN - 32;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  low_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;
    logic             neg_r;
    logic             is_rem;
    logic             is_w;

    // ---- accept-side operand preparation ----
    logic            sgn;
    logic            w;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res;
    logic [XLEN-1:0] spec_res, low_init;
    logic            a_neg, b_neg, b_zero, ovf, special;
    logic [CNT_W-1:0] cnt_init;

    assign sgn = op_signed(bus.req_op_i);
    assign w   = bus.req_w_i;

    always_comb begin
        a_ext = bus.req_dvnd_i;
        b_ext = bus.req_dvsr_i;
        if (w) begin
            a_ext = sgn ? sext32(bus.req_dvnd_i[31:0])
                        : XLEN'(bus.req_dvnd_i[31:0]);
            b_ext = sgn ? sext32(bus.req_dvsr_i[31:0])
                        : XLEN'(bus.req_dvsr_i[31:0]);
        end
        a_neg = sgn & a_ext[XLEN-1];
        b_neg = sgn & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        // W magnitudes fit in 32 bits; left-align into the low register.
        low_init = w ? (a_mag << HALF) : a_mag;
        a_res = w ? sext32(bus.req_dvnd_i[31:0]) : bus.req_dvnd_i;
        b_zero = w ? (bus.req_dvsr_i[31:0] == 32'h0)
                   : (bus.req_dvsr_i == '0);
        ovf = sgn & (w ? (bus.req_dvnd_i[31:0] == 32'h8000_0000 &&
                          bus.req_dvsr_i[31:0] == 32'hFFFF_FFFF)
                       : (bus.req_dvnd_i == MIN_NEG &&
                          bus.req_dvsr_i == '1));
        special = b_zero | ovf;
        if (b_zero)
            spec_res = op_rem(bus.req_op_i) ? a_res : '1;
        else
            spec_res = op_rem(bus.req_op_i) ? '0 : a_res;
        cnt_init = w ? CNT_W'(32 / BITS_PER_CYCLE - 1)
                     : CNT_W'(XLEN / BITS_PER_CYCLE - 1);
    end

    // ---- iteration datapath ----
    logic [XLEN-1:0]           rem_c [BITS_PER_CYCLE+1];
    logic [XLEN-1:0]           low_c [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bit;

    assign rem_c[0] = rem_q;
    assign low_c[0] = low_q;

    // Quotient bits shift in at the bottom as dividend bits leave the top.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem      (rem_c[i]),
            .dvnd_bit (low_c[i][XLEN-1]),
            .dvsr     (dvsr_q),
            .rem_next (rem_c[i+1]),
            .q_bit    (q_bit[i])
        );
        assign low_c[i+1] = {low_c[i][XLEN-2:0], q_bit[i]};
    end

    logic [XLEN-1:0] fin_val, fin_sgn, fin_res;

    always_comb begin
        fin_val = is_rem ? rem_c[BITS_PER_CYCLE] : low_c[BITS_PER_CYCLE];
        fin_sgn = (is_rem ? neg_r : neg_q) ? -fin_val : fin_val;
        fin_res = is_w ? sext32(fin_sgn[31:0]) : fin_sgn;
    end

    // ---- handshake ----
    logic ready;
    logic accept;

    always_comb begin
        ready = 1'b0;
        unique case (state)
            IDLE:    ready = ~kill_i;
            DONE:    ready = bus.resp_ready_i & ~kill_i;
            default: ready = 1'b0;
        endcase
    end

    assign accept            = bus.req_valid_i & ready;
    assign bus.req_ready_o   = ready;
    assign bus.resp_valid_o  = (state == DONE);
    assign bus.resp_result_o = result_q;
    assign bus.resp_tag_o    = tag_q;
    assign busy_o            = (state != IDLE);

    // ---- control FSM and state registers ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            rem_q    <= '0;
            low_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            is_w     <= 1'b0;
        end else if (kill_i) begin
            state <= IDLE;
        end else if (accept) begin
            tag_q  <= bus.req_tag_i;
            is_rem <= op_rem(bus.req_op_i);
            is_w   <= w;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            rem_q  <= '0;
            low_q  <= low_init;
            dvsr_q <= b_mag;
            cnt    <= cnt_init;
            if (special) begin
                result_q <= spec_res;
                state    <= DONE;
            end else begin
                state <= ITER;
            end
        end else begin
            unique case (state)
                ITER: begin
                    rem_q <= rem_c[BITS_PER_CYCLE];
                    low_q <= low_c[BITS_PER_CYCLE];
                    if (cnt == '0) begin
                        result_q <= fin_res;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready_i)
                        state <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit (two instances: 1 and 2 bits/cycle).
// Table vectors, hand sequences for stall/kill/reset, randomized ops vs model.
module tb_iter_div_unit;
    import drac_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, resp_ready, kill;
    div_op_t     req_op   [2];
    logic        req_w    [2];
    logic [5:0]  req_tag  [2];
    logic [63:0] req_dvnd [2];
    logic [63:0] req_dvsr [2];
    wire  [1:0]  req_ready, resp_valid, busy;
    wire  [63:0] resp_result [2];
    wire  [5:0]  resp_tag    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        iter_div_unit_if #(.XLEN(64), .TAG_W(6)) bus ();
        assign bus.req_valid_i  = req_valid[g];
        assign bus.req_op_i     = req_op[g];
        assign bus.req_w_i      = req_w[g];
        assign bus.req_tag_i    = req_tag[g];
        assign bus.req_dvnd_i   = req_dvnd[g];
        assign bus.req_dvsr_i   = req_dvsr[g];
        assign bus.resp_ready_i = resp_ready[g];
        assign req_ready[g]     = bus.req_ready_o;
        assign resp_valid[g]    = bus.resp_valid_o;
        assign resp_result[g]   = bus.resp_result_o;
        assign resp_tag[g]      = bus.resp_tag_o;
        iter_div_unit #(
            .XLEN(64), .BITS_PER_CYCLE(g + 1), .TAG_W(6)
        ) dut (
            .clk_i  (clk),
            .rst_i  (rst),
            .kill_i (kill[g]),
            .bus    (bus),
            .busy_o (busy[g])
        );
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics with plain arithmetic.
    function automatic logic [63:0] model(div_op_t op, bit w,
                                          logic [63:0] a, logic [63:0] b);
        bit sgn = (op == DIV) || (op == REM);
        bit rem = (op == REM) || (op == REMU);
        logic [31:0] a32 = a[31:0];
        logic [31:0] b32 = b[31:0];
        logic [31:0] q32, r32, p32;
        logic [63:0] q, r;
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == '1) begin
                q32 = a32; r32 = 0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            p32 = rem ? r32 : q32;
            return {{32{p32[31]}}, p32};
        end
        if (b == 0) begin q = '1; r = a; end
        else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return rem ? r : q;
    endfunction

    function automatic int exp_lat(int u, div_op_t op, bit w,
                                   logic [63:0] a, logic [63:0] b);
        bit sgn = (op == DIV) || (op == REM);
        bit z = w ? (b[31:0] == 0) : (b == 0);
        bit o = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                          : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (z || o) return 1;
        return (w ? 32 : 64) / (u + 1) + 1;
    endfunction

    task automatic present(input int u, input div_op_t op, input bit w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [5:0] tag);
        req_valid[u] = 1'b1;
        req_op[u]    = op;
        req_w[u]     = w;
        req_dvnd[u]  = a;
        req_dvsr[u]  = b;
        req_tag[u]   = tag;
    endtask

    task automatic do_op(input int u, input div_op_t op, input bit w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tag, output logic [63:0] res,
                         output logic [5:0] rtag, output int lat);
        @(negedge clk);
        present(u, op, w, a, b, tag);
        @(posedge clk);
        #1 req_valid[u] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid[u] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        res  = resp_result[u];
        rtag = resp_tag[u];
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1 resp_ready[u] = 1'b0;
    endtask

    typedef struct {
        int          u;
        div_op_t     op;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  tag;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vt [12];
    logic [63:0] res;
    logic [5:0]  rtag;
    int          lat;
    bit          saw;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        kill = '0;
        for (int u = 0; u < 2; u++) present(u, DIV, 1'b0, 64'h0, 64'h0, 6'h0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d_valid", u), 64'(resp_valid[u]), 64'd0);
            chk($sformatf("rst%0d_result", u), resp_result[u], 64'd0);
            chk($sformatf("rst%0d_tag", u), 64'(resp_tag[u]), 64'd0);
            chk($sformatf("rst%0d_busy", u), 64'(busy[u]), 64'd0);
            chk($sformatf("rst%0d_ready", u), 64'(req_ready[u]), 64'd1);
        end

        vt[0]  = '{0, DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'h01,
                   64'hFFFF_FFFF_FFFF_FFFD, 65};
        vt[1]  = '{0, REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'h02,
                   64'hFFFF_FFFF_FFFF_FFFF, 65};
        vt[2]  = '{0, DIVU, 1'b0, 64'd5, 64'd0, 6'h03,
                   64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[3]  = '{0, REMU, 1'b0, 64'd5, 64'd0, 6'h04, 64'd5, 1};
        vt[4]  = '{0, DIV,  1'b0, 64'h8000_0000_0000_0000,
                   64'hFFFF_FFFF_FFFF_FFFF, 6'h05,
                   64'h8000_0000_0000_0000, 1};
        vt[5]  = '{0, REM,  1'b0, 64'h8000_0000_0000_0000,
                   64'hFFFF_FFFF_FFFF_FFFF, 6'h06, 64'd0, 1};
        vt[6]  = '{0, DIV,  1'b1, 64'h0000_0000_8000_0000,
                   64'h0000_0000_FFFF_FFFF, 6'h07,
                   64'hFFFF_FFFF_8000_0000, 1};
        vt[7]  = '{1, DIVU, 1'b1, 64'd100, 64'd7, 6'h2A, 64'd14, 17};
        vt[8]  = '{1, REMU, 1'b1, 64'd100, 64'd7, 6'h2A, 64'd2, 17};
        vt[9]  = '{0, DIVU, 1'b1, 64'd100, 64'd7, 6'h11, 64'd14, 33};
        vt[10] = '{1, DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'h12,
                   64'hFFFF_FFFF_FFFF_FFF2, 33};
        vt[11] = '{0, REM,  1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 6'h13,
                   64'hFFFF_FFFF_FFFF_FFFE, 33};

        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].u, vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].tag,
                  res, rtag, lat);
            chk($sformatf("vec%0d_res", i), res, vt[i].exp);
            chk($sformatf("vec%0d_tag", i), 64'(rtag), 64'(vt[i].tag));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
        end

        // Backpressure: hold the result, then accept back-to-back.
        @(negedge clk);
        present(0, DIVU, 1'b0, 64'd1000, 64'd3, 6'h05);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!resp_valid[0] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", 64'(lat), 64'd65);
        present(0, DIVU, 1'b0, 64'd77, 64'd0, 6'h06);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_res", resp_result[0], 64'd333);
            chk("bp_hold_tag", 64'(resp_tag[0]), 64'h05);
            chk("bp_hold_valid", 64'(resp_valid[0]), 64'd1);
            chk("bp_hold_ready", 64'(req_ready[0]), 64'd0);
        end
        resp_ready[0] = 1'b1;
        #1 chk("bp_rel_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 64'(resp_valid[0]), 64'd1);
        chk("b2b_res", resp_result[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b2b_tag", 64'(resp_tag[0]), 64'h06);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;

        // Kill at ITER cycle 20.
        @(negedge clk);
        present(0, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 6'h09);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        kill[0] = 1'b1;
        @(posedge clk);
        #1 kill[0] = 1'b0;
        @(negedge clk);
        chk("kill_busy", 64'(busy[0]), 64'd0);
        chk("kill_valid", 64'(resp_valid[0]), 64'd0);
        saw = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (resp_valid[0]) saw = 1'b1;
        end
        chk("kill_no_resp", 64'(saw), 64'd0);

        // Kill while idle blocks a same-cycle request.
        present(0, DIVU, 1'b0, 64'd9, 64'd0, 6'h0A);
        kill[0] = 1'b1;
        #1 chk("kill_idle_ready", 64'(req_ready[0]), 64'd0);
        @(posedge clk);
        #1 kill[0] = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("kill_idle_busy", 64'(busy[0]), 64'd0);

        do_op(0, DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 6'h0B,
              res, rtag, lat);
        chk("post_kill_res", res, 64'hFFFF_FFFF_FFFF_FF72);
        chk("post_kill_tag", 64'(rtag), 64'h0B);
        chk("post_kill_lat", 64'(lat), 64'd65);

        // Reset mid-ITER on the 2-bit instance.
        @(negedge clk);
        present(1, DIV, 1'b0, 64'd12345, 64'd11, 6'h33);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(resp_valid[1]), 64'd0);
        chk("mrst_result", resp_result[1], 64'd0);
        chk("mrst_tag", 64'(resp_tag[1]), 64'd0);
        chk("mrst_busy", 64'(busy[1]), 64'd0);
        chk("mrst_ready", 64'(req_ready[1]), 64'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            int          u;
            int          mode;
            div_op_t     op;
            bit          w;
            logic [63:0] a, b;
            logic [5:0]  tag;
            u    = int'($urandom_range(0, 1));
            op   = div_op_t'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            tag  = 6'($urandom);
            mode = int'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom} >> $urandom_range(0, 63);
            case (mode)
                0: b = w ? {$urandom, 32'h0} : 64'h0;
                1: begin
                    b = '1;
                    a = w ? {$urandom, 32'h8000_0000}
                          : 64'h8000_0000_0000_0000;
                end
                2: begin
                    a = 64'($urandom_range(0, 1000));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    b = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: ;
            endcase
            do_op(u, op, w, a, b, tag, res, rtag, lat);
            chk($sformatf("rand%0d_res", i), res, model(op, w, a, b));
            chk($sformatf("rand%0d_tag", i), 64'(rtag), 64'(tag));
            chk($sformatf("rand%0d_lat", i), 64'(lat),
                64'(exp_lat(u, op, w, a, b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
